dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Parameters
REQ-001 The block SHALL have parameter LATENCY, default 4, giving the cycles from request acceptance to ack_o (legal range 1..15).
REQ-002 The block SHALL have parameter MEM_WORDS, default 256, giving the number of 32-bit words in storage.

Interface
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_i, input, 1 bit: MEM-stage access request valid.
REQ-006 The block SHALL have port we_i, input, 1 bit: 1 = write, 0 = read; sampled with req_i.
REQ-007 The block SHALL have port addr_i, input, 32 bits: byte address; word index is addr_i[9:2] for MEM_WORDS=256.
REQ-008 The block SHALL have port wdata_i, input, 32 bits: write data.
REQ-009 The block SHALL have port ready_o, output, 1 bit: request may be accepted this cycle.
REQ-010 The block SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port rdata_o, output, 32 bits: read data, valid when ack_o=1.
REQ-012 The block SHALL have port err_o, output, 1 bit: access error, valid when ack_o=1.
REQ-013 The block SHALL have port stall_o, output, 1 bit: freeze request to the CPU pipeline.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and RESP, with ready_o=1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge where req_i=1 and ready_o=1; the edge latches we_i, addr_i and wdata_i into internal registers.
REQ-016 On acceptance, the FSM SHALL move IDLE->BUSY with the down-counter loaded to LATENCY-2 when LATENCY>=2, or IDLE->RESP when LATENCY=1.
REQ-017 In BUSY, the counter SHALL decrement each cycle, and the FSM SHALL move BUSY->RESP on the edge where the counter equals 0.
REQ-018 ack_o SHALL be high for exactly one cycle, in RESP, exactly LATENCY cycles after the accepting edge; RESP->IDLE is unconditional.
REQ-019 A read SHALL drive rdata_o with mem[word index] during RESP, and rdata_o SHALL hold its last value otherwise.
REQ-020 A write SHALL commit to storage on the edge leaving RESP, so a read accepted afterwards returns the new data.
REQ-021 A request with addr_i[1:0]!=0, or with a word index >= MEM_WORDS, SHALL be an error: go directly to RESP, ack_o=1, err_o=1, rdata_o=0, no write.
REQ-022 stall_o SHALL equal (IDLE & req_i & no error) | BUSY, combinationally, and SHALL be 0 in RESP so the pipeline advances with the ack.
REQ-023 req_i in BUSY or RESP SHALL be ignored, not queued, and input changes during BUSY SHALL NOT alter the latched request.
REQ-024 A request SHALL be accepted in the IDLE cycle immediately following RESP, giving back-to-back throughput of one access per LATENCY+1 cycles.

Reset
REQ-025 rst_i=0 SHALL force, asynchronously, state=IDLE, counter=0, ack_o=0, err_o=0, rdata_o=0 and the latched request registers to 0.
REQ-026 Reset during BUSY or RESP SHALL abort the access with no write and no ack.
REQ-027 Storage contents SHALL NOT be cleared by reset.
REQ-028 After rst_i returns to 1, ready_o SHALL be 1 in the first cycle.

Structure
REQ-029 Package dmem_pkg SHALL hold the FSM state enum, the LATENCY default, the MEM_WORDS default and the counter width constant (4).
REQ-030 Storage SHALL be one sub-module, dmem_array: synchronous write, combinational read, MEM_WORDS x 32.
REQ-031 The FSM, counter and error check SHALL reside in dmem_responder.

Verification
REQ-032 Bench SHALL cover: LATENCY=4, write 0xDEADBEEF to 0x10 accepted at edge 0 -> stall_o=1 through cycle 3, ack_o=1 in cycle 4 only, err_o=0.
REQ-033 Bench SHALL cover: read 0x10 immediately after REQ-032 completes -> accepted next IDLE cycle, ack 4 cycles later, rdata_o=0xDEADBEEF.
REQ-034 Bench SHALL cover: read 0x13 (misaligned) and read 0x400 (out of range) -> ack_o next cycle, err_o=1, rdata_o=0, storage unchanged.
REQ-035 Bench SHALL cover: write 0x55 to 0x20, rst_i=0 in cycle 2 -> ack_o never asserted, a later read of 0x20 returns its prior value.
REQ-036 Bench SHALL cover: LATENCY=1, back-to-back reads of 0x0 and 0x4 with req_i held high -> acks in cycles 1 and 3, ready_o low in the RESP cycles.
REQ-037 Bench SHALL cover: wdata_i/addr_i toggled during BUSY -> committed data equals the values latched at acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared FSM state type, parameter defaults and counter width for the data-memory responder.
// Imported by dmem_array and dmem_responder; holds no logic of its own.
package dmem_pkg;

  localparam int LATENCY_DEF   = 4;
  localparam int MEM_WORDS_DEF = 256;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // BUSY is left on the edge where the counter reads zero, so the load value is
  // two short of the total latency (one edge to enter BUSY, one to leave it).
  function automatic logic [CNT_W-1:0] busy_load(input int latency);
    return CNT_W'(latency - 2);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// MEM_WORDS x 32 storage: synchronous write, combinational read, contents never reset.
// Latency: write lands on the clock edge, read is same-cycle; no backpressure.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one access in flight, ack LATENCY cycles after acceptance.
// Address errors ack on the next cycle; ready_o only in IDLE, new requests while busy are dropped.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY   = LATENCY_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             addr_err;
  logic             mem_we;
  logic [31:0]      mem_rdata;

  // Misaligned, or word index past the end of storage; checks every address bit.
  assign addr_err = (addr_i[1:0] != 2'b00) ||
                    ({2'b00, addr_i[31:2]} >= 32'(MEM_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    ready_o = 1'b0;
    ack_o   = 1'b0;
    err_o   = 1'b0;
    stall_o = 1'b0;
    rdata_o = rdata_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          we_d    = we_i;
          widx_d  = addr_i[IDX_W+1:2];
          wdata_d = wdata_i;
          err_d   = addr_err;
          stall_o = !addr_err;
          if (addr_err || (LATENCY == 1)) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = busy_load(LATENCY);
          end
        end
      end

      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        ack_o   = 1'b1;
        err_o   = err_q;
        if (err_q) begin
          rdata_o = '0;
        end else if (!we_q) begin
          rdata_o = mem_rdata;
        end
        // Commit happens on the edge leaving RESP; an async reset here kills it.
        mem_we  = we_q && !err_q;
        rdata_d = rdata_o;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  dmem_array #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (widx_q),
    .wdata_i (wdata_q),
    .raddr_i (widx_q),
    .rdata_o (mem_rdata)
  );

endmodule
